// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digit cascade.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// Single decade counter digit with synchronous clear and count enable.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       at_max
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaler, run/pause/lap FSM, lap snapshot and a
// synchronous BCD digit cascade whose enables are decoded from one tick.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic [4*N_DIGITS-1:0] disp_bcd,
  output logic                  running,
  output logic                  tick,
  output logic                  overflow
);

  localparam int unsigned CW = 4 * N_DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] snap_q, snap_d;
  logic          ovf_q, ovf_d;
  logic          clr_cnt;
  logic          run_c;
  logic          tick_c;
  logic [N_DIGITS:0]   carry;
  logic [N_DIGITS-1:0] at_max;

  assign run_c  = (state_q == RUN) || (state_q == LAP);
  assign tick_c = run_c && (presc_q == PW'(TICK_DIV - 1));

  // Next state, snapshot capture and the count-clear strobe for PAUSE -> IDLE
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    clr_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) state_d = RUN;
      end
      RUN: begin
        if (start_stop) begin
          state_d = PAUSE;
        end else if (lap) begin
          state_d = LAP;
          snap_d  = count_bcd;
        end
      end
      LAP: begin
        if (start_stop)  state_d = PAUSE;
        else if (lap)    state_d = RUN;
      end
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
          clr_cnt = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    if (clr_cnt) begin
      presc_d = '0;
    end else if (run_c) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
    end
    ovf_d = clr_cnt ? 1'b0 : (ovf_q | carry[N_DIGITS]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Carry chain is decoded from current digit values, so all digits step on one edge
  assign carry[0] = tick_c;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr_cnt),
      .en     (carry[k]),
      .q      (count_bcd[4*k +: 4]),
      .at_max (at_max[k])
    );
    assign carry[k+1] = carry[k] & at_max[k];
  end

  assign disp_bcd = (state_q == LAP) ? snap_q : count_bcd;
  assign running  = run_c;
  assign tick     = tick_c;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (2 digits, divide-by-2 prescaler):
// fixed vector table, directed corner sequences and a randomized run against a reference model.
module tb_stopwatch_ctrl;

  localparam int unsigned ND   = 2;
  localparam int unsigned TDIV = 2;
  localparam int          MAXV = 99;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_stop = 1'b0;
  logic         lap = 1'b0;
  logic         clear = 1'b0;
  logic [7:0]   count_bcd;
  logic [7:0]   disp_bcd;
  logic         running;
  logic         tick;
  logic         overflow;

  stopwatch_ctrl #(.N_DIGITS(ND), .TICK_DIV(TDIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .count_bcd  (count_bcd),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .tick       (tick),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: decimal count value plus plain integers for everything else
  int m_st, m_cnt, m_presc, m_snap;
  bit m_ovf;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [18:0] model_out();
    bit run;
    bit tk;
    run = (m_st == M_RUN) || (m_st == M_LAP);
    tk  = run && (m_presc == TDIV - 1);
    return {to_bcd(m_cnt), (m_st == M_LAP) ? to_bcd(m_snap) : to_bcd(m_cnt), run, tk, m_ovf};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_presc = 0; m_snap = 0; m_ovf = 1'b0;
  endtask

  task automatic model_update(input bit sa, input bit lp, input bit cl);
    bit run;
    bit tk;
    int pre;
    run = (m_st == M_RUN) || (m_st == M_LAP);
    tk  = run && (m_presc == TDIV - 1);
    pre = m_cnt;
    if (tk) begin
      if (m_cnt == MAXV) m_ovf = 1'b1;
      m_cnt = (m_cnt + 1) % (MAXV + 1);
    end
    if (run) m_presc = tk ? 0 : m_presc + 1;
    case (m_st)
      M_IDLE:  if (sa) m_st = M_RUN;
      M_RUN:   if (sa) m_st = M_PAUSE;
               else if (lp) begin m_st = M_LAP; m_snap = pre; end
      M_LAP:   if (sa) m_st = M_PAUSE;
               else if (lp) m_st = M_RUN;
      default: if (cl) begin
                 m_st = M_IDLE; m_cnt = 0; m_presc = 0; m_ovf = 1'b0;
               end else if (sa) m_st = M_RUN;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [18:0] dut_out();
    return {count_bcd, disp_bcd, running, tick, overflow};
  endfunction

  // Entered and left at a negedge: drive, clock, update model, compare
  task automatic step(input bit sa, input bit lp, input bit cl);
    start_stop = sa; lap = lp; clear = cl;
    @(posedge clk);
    model_update(sa, lp, cl);
    @(negedge clk);
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    chk("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    #1;
    model_reset();
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         sa, lp, cl;
    logic [7:0] cnt, disp;
    logic       run, tk, ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int guard;
    int ticks;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h02, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].sa, vecs[i].lp, vecs[i].cl);
      chk($sformatf("vec%0d", i), 32'({count_bcd, disp_bcd, running, tick, overflow}),
          32'({vecs[i].cnt, vecs[i].disp, vecs[i].run, vecs[i].tk, vecs[i].ovf}));
    end

    // Free run: 20 cycles at divide-by-2 gives ten ticks
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (tick) ticks++;
      step(1'b0, 1'b0, 1'b0);
    end
    chk("run20_count", 32'(count_bcd), 32'h10);
    chk("run20_running", 32'(running), 32'd1);
    chk("run20_ticks", 32'(ticks), 32'd10);

    // Wrap from 99 to 00 sets overflow; only PAUSE->clear removes it
    guard = 0;
    while (m_cnt != MAXV) begin
      step(1'b0, 1'b0, 1'b0);
      if (++guard > 1000) begin timeout_fail("reach_99"); break; end
    end
    chk("at_99", 32'(count_bcd), 32'h99);
    guard = 0;
    while (!m_ovf) begin
      step(1'b0, 1'b0, 1'b0);
      if (++guard > 10) begin timeout_fail("wrap"); break; end
    end
    chk("wrap_count", 32'(count_bcd), 32'h00);
    chk("wrap_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("ovf_sticky_pause", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("clear_ovf", 32'({overflow, running, count_bcd}), 32'd0);

    // Lap coinciding with a tick snapshots the pre-increment value
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!(m_cnt == 5 && m_presc == TDIV - 1)) begin
      step(1'b0, 1'b0, 1'b0);
      if (++guard > 100) begin timeout_fail("reach_05"); break; end
    end
    chk("lap_tick_coincide", 32'(tick), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("lap_disp_frozen", 32'(disp_bcd), 32'h05);
    chk("lap_count_live", 32'(count_bcd), 32'h08);
    step(1'b0, 1'b1, 1'b0);
    chk("unlap_disp", 32'(disp_bcd), 32'(to_bcd(m_cnt)));
    chk("unlap_running", 32'(running), 32'd1);

    // Pause holds the prescaler phase; resume ticks after one cycle; clear ignored in RUN
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!(m_cnt == 7 && m_presc == 0)) begin
      step(1'b0, 1'b0, 1'b0);
      if (++guard > 100) begin timeout_fail("reach_07"); break; end
    end
    step(1'b1, 1'b0, 1'b0);
    chk("pause_running", 32'(running), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    chk("pause_hold", 32'(count_bcd), 32'h07);
    step(1'b1, 1'b0, 1'b0);
    chk("resume_tick", 32'({tick, count_bcd}), 32'h107);
    step(1'b0, 1'b0, 1'b1);
    chk("clear_in_run", 32'({running, count_bcd}), 32'h108);

    // start_stop and clear together in PAUSE: clear wins
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("pause_both", 32'({running, count_bcd}), 32'h000);

    // Asynchronous reset between edges mid-run
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (m_cnt != 42) begin
      step(1'b0, 1'b0, 1'b0);
      if (++guard > 200) begin timeout_fail("reach_42"); break; end
    end
    chk("pre_async", 32'(count_bcd), 32'h42);
    #2 reset = 1'b1;
    #1 chk("async_reset", 32'(dut_out()), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("post_async_idle", 32'({running, count_bcd}), 32'd0);

    // Randomized button traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
